// File: rtl/fsm_input_conditioner.sv
// Input conditioner for the protocol FSM: synchronizes the 2-bit raw symbol and debounces it as one
// vector. Optional build macro FSM_IC_ONESHOT_EN presents each accepted symbol on E for one cycle.
module fsm_input_conditioner #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] raw_in,
    output logic [1:0] E,
    output logic       e_change,
    output logic       busy
);

    localparam int unsigned CNT_W =
        ($clog2(DEBOUNCE_CYCLES) > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {StStable, StQual} state_e;

    logic [1:0]       r_sync [SYNC_STAGES];
    logic [1:0]       w_sync_q;
    state_e           r_state, w_state_next;
    logic [1:0]       r_stable, w_stable_next;
    logic [1:0]       r_cand, w_cand_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic             w_accept;
    logic [1:0]       r_e, w_e_next;
    logic             r_e_change;
    logic             r_busy, w_busy_next;

    // Plain flop chain: no logic between stages.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) r_sync[i] <= 2'b00;
        end else begin
            r_sync[0] <= raw_in;
            for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= StStable;
            r_stable <= 2'b00;
            r_cand   <= 2'b00;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_stable <= w_stable_next;
            r_cand   <= w_cand_next;
            r_cnt    <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_stable_next = r_stable;
        w_cand_next   = r_cand;
        w_cnt_next    = r_cnt;
        w_accept      = 1'b0;
        unique case (r_state)
            StStable: begin
                if (w_sync_q != r_stable) begin
                    w_cand_next  = w_sync_q;
                    w_cnt_next   = '0;
                    w_state_next = StQual;
                end
            end
            StQual: begin
                if (w_sync_q == r_cand) begin
                    // Compare before incrementing so the counter never wraps.
                    if (r_cnt == CNT_LAST) begin
                        w_stable_next = r_cand;
                        w_accept      = 1'b1;
                        w_state_next  = StStable;
                    end else begin
                        w_cnt_next = r_cnt + CNT_W'(1);
                    end
                end else if (w_sync_q == r_stable) begin
                    w_state_next = StStable;
                end else begin
                    w_cand_next = w_sync_q;
                    w_cnt_next  = '0;
                end
            end
            default: w_state_next = StStable;
        endcase
    end

    always_comb begin
        w_busy_next = (w_state_next == StQual);
`ifdef FSM_IC_ONESHOT_EN
        w_e_next = w_accept ? w_stable_next : 2'b00;
`else
        w_e_next = w_stable_next;
`endif
    end

    // Outputs come straight from flops, updated on the same edge as the state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_e        <= 2'b00;
            r_e_change <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_e        <= w_e_next;
            r_e_change <= w_accept;
            r_busy     <= w_busy_next;
        end
    end

    assign E        = r_e;
    assign e_change = r_e_change;
    assign busy     = r_busy;

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Bench for fsm_input_conditioner: directed scenarios with literal expectations plus randomized
// stimulus compared every cycle against a streak-counting reference model.
module tb_fsm_input_conditioner;

    localparam int unsigned SYNC = 2;
    localparam int unsigned DEB  = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] raw_in = 2'b00;
    logic [1:0] E;
    logic       e_change;
    logic       busy;

    fsm_input_conditioner #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .raw_in  (raw_in),
        .E       (E),
        .e_change(e_change),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: sync_q is raw_in delayed SYNC samples; a value different from the
    // accepted one is accepted once it has been seen DEB+1 times in a row.
    logic [1:0] m_sh [SYNC];
    logic [1:0] m_stable = 2'b00;
    logic [1:0] m_cand   = 2'b00;
    int         m_streak = 0;
    logic [1:0] m_e      = 2'b00;
    logic       m_chg    = 1'b0;
    logic       m_busy   = 1'b0;

    always @(posedge clk or posedge reset) begin
        logic [1:0] v;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_sh[i] = 2'b00;
            m_stable = 2'b00;
            m_cand   = 2'b00;
            m_streak = 0;
            m_e      = 2'b00;
            m_chg    = 1'b0;
            m_busy   = 1'b0;
        end else begin
            v     = m_sh[SYNC-1];
            m_chg = 1'b0;
            if (v == m_stable) begin
                m_streak = 0;
            end else if (m_streak > 0 && v == m_cand) begin
                m_streak++;
            end else begin
                m_cand   = v;
                m_streak = 1;
            end
            if (m_streak == DEB + 1) begin
                m_stable = v;
                m_chg    = 1'b1;
                m_streak = 0;
            end
            m_busy = (m_streak > 0);
`ifdef FSM_IC_ONESHOT_EN
            m_e = m_chg ? m_stable : 2'b00;
`else
            m_e = m_stable;
`endif
            for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
            m_sh[0] = raw_in;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("model {E,e_change,busy}", {E, e_change, busy}, {m_e, m_chg, m_busy});
    end

    // Monitors used by the directed scenarios.
    int n_chg    = 0;
    bit saw11    = 1'b0;
    bit saw_busy = 1'b0;
    bit saw_e    = 1'b0;
    always @(posedge clk) begin
        #2;
        if (e_change) n_chg++;
        if (E == 2'b11) saw11 = 1'b1;
        if (busy) saw_busy = 1'b1;
        if (E != 2'b00) saw_e = 1'b1;
    end

    task automatic clr_mon();
        n_chg    = 0;
        saw11    = 1'b0;
        saw_busy = 1'b0;
        saw_e    = 1'b0;
    endtask

    int ones;
    int hold;

    initial begin
        // T1: reset with 11 on the pads.
        #1 reset = 1'b1;
        raw_in = 2'b11;
        repeat (4) @(posedge clk);
        #2;
        chk("T1 reset E", E, 0);
        chk("T1 reset e_change", e_change, 0);
        chk("T1 reset busy", busy, 0);
        @(negedge clk);
        raw_in = 2'b00;
        reset  = 1'b0;
        clr_mon();
        repeat (25) @(negedge clk);
        chk("T1 post E", E, 0);
        chk("T1 post busy seen", saw_busy, 0);

        // T3: 10-cycle glitch is rejected.
        clr_mon();
        raw_in = 2'b10;
        repeat (10) @(negedge clk);
        raw_in = 2'b00;
        repeat (30) @(negedge clk);
        chk("T3 busy pulsed", saw_busy, 1);
        chk("T3 E stayed 00", saw_e, 0);
        chk("T3 no e_change", n_chg, 0);
        chk("T3 busy idle", busy, 0);

        // T2/T6: 00->01 held 100 cycles, edge 1 is the first edge after the change.
        raw_in = 2'b01;
        ones   = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #2;
            if (E == 2'b01) ones++;
            if (k == 18) begin
                chk("T2 E before edge 19", E, 0);
                chk("T2 busy before edge 19", busy, 1);
                chk("T2 e_change before edge 19", e_change, 0);
            end
            if (k == 19) begin
                chk("T2 E at edge 19", E, 1);
                chk("T2 e_change at edge 19", e_change, 1);
                chk("T2 busy at edge 19", busy, 0);
            end
            if (k == 20) chk("T2 e_change drop", e_change, 0);
        end
`ifdef FSM_IC_ONESHOT_EN
        chk("T6 cycles with E=01", ones, 1);
`else
        chk("T6 cycles with E=01", ones, 82);
`endif

        // T4: 01 -> 11 (3 cycles) -> 10 held.
        @(negedge clk);
        clr_mon();
        raw_in = 2'b11;
        repeat (3) @(negedge clk);
        raw_in = 2'b10;
        repeat (40) @(negedge clk);
        chk("T4 never 11", saw11, 0);
        chk("T4 one e_change", n_chg, 1);
`ifndef FSM_IC_ONESHOT_EN
        chk("T4 final E", E, 2);
`endif

        // T5: reset 8 cycles into qualification of 11.
        raw_in = 2'b00;
        repeat (25) @(negedge clk);
        raw_in = 2'b11;
        repeat (8) @(negedge clk);
        chk("T5 busy before reset", busy, 1);
        reset = 1'b1;
        #1;
        chk("T5 reset E", E, 0);
        chk("T5 reset busy", busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 19; k++) begin
            @(posedge clk);
            #2;
            if (k == 18) chk("T5 E before edge 19", E, 0);
            if (k == 19) begin
                chk("T5 E at edge 19", E, 3);
                chk("T5 e_change at edge 19", e_change, 1);
            end
        end

        // Random phase: held values of random length, occasional short resets.
        for (int n = 0; n < 150; n++) begin
            @(negedge clk);
            raw_in = 2'($urandom);
            hold   = (($urandom % 3) == 0) ? int'($urandom_range(1, 16)) :
                                             int'($urandom_range(17, 40));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end
            repeat (hold) @(negedge clk);
        end
        repeat (30) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
